memory_controller: RTL and testbench

MEMORY_CONTROLLER -- requirements
Module: memory_controller

---
 rtl/memory_map_pkg.sv | 36 +++
 rtl/memory_controller_if.sv | 25 ++
 rtl/ram_bank.sv | 23 ++
 rtl/memory_controller.sv | 129 ++++++++++++
 tb/tb_memory_controller.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/memory_map_pkg.sv
// Shared memory map for the CPU, display and memory controller: region bounds,
// region and VRAM arbiter enums, and the CPU address decoder.
package memory_map_pkg;

  localparam int WORD_W   = 16;
  localparam int CPU_AW   = 16;
  localparam int VID_AW   = 13;

  localparam logic [CPU_AW-1:0] RAM_BASE   = 16'h0000;
  localparam logic [CPU_AW-1:0] RAM_LIMIT  = 16'h3FFF;
  localparam logic [CPU_AW-1:0] VRAM_BASE  = 16'h4000;
  localparam logic [CPU_AW-1:0] VRAM_LIMIT = 16'h5FFF;
  localparam logic [CPU_AW-1:0] KBD_ADDR   = 16'h6000;

  typedef enum logic [1:0] {
    RAM  = 2'd0,
    VRAM = 2'd1,
    KBD  = 2'd2,
    NONE = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    VID_OWN = 2'd1,
    GUARD   = 2'd2
  } arb_state_e;

  // RAM_BASE is zero, so only the upper limits need comparing.
  function automatic region_e decode_region(input logic [CPU_AW-1:0] addr);
    if (addr <= RAM_LIMIT)       return RAM;
    else if (addr <= VRAM_LIMIT) return VRAM;
    else if (addr == KBD_ADDR)   return KBD;
    else                         return NONE;
  endfunction

endpackage

// File: rtl/memory_controller_if.sv
// CPU, video and keyboard signal bundle of the memory controller.
interface memory_controller_if;
  import memory_map_pkg::*;

  logic              cpu_load;
  logic [CPU_AW-1:0] cpu_address;
  logic [WORD_W-1:0] cpu_wdata;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_busy;
  logic              vid_req;
  logic [VID_AW-1:0] vid_address;
  logic [WORD_W-1:0] vid_rdata;
  logic              vid_valid;
  logic [WORD_W-1:0] kbd_code;

  modport master (
    output cpu_load, cpu_address, cpu_wdata, vid_req, vid_address, kbd_code,
    input  cpu_rdata, cpu_busy, vid_rdata, vid_valid
  );

  modport slave (
    input  cpu_load, cpu_address, cpu_wdata, vid_req, vid_address, kbd_code,
    output cpu_rdata, cpu_busy, vid_rdata, vid_valid
  );
endinterface

// File: rtl/ram_bank.sv
// Single-port synchronous RAM with a registered (1-cycle) read; read-before-write.
module ram_bank
  import memory_map_pkg::*;
#(
  parameter int WORDS  = 1024,
  parameter int ADDR_W = $clog2(WORDS),
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_controller.sv
// CPU/video memory controller: data RAM, arbitrated VRAM and keyboard port.
// Define MEMORY_CONTROLLER_KEYBOARD_EN to map the keyboard register at 0x6000.
module memory_controller
  import memory_map_pkg::*;
#(
  parameter int RAM_WORDS  = 16384,
  parameter int VRAM_WORDS = 8192
) (
  input  logic          clk,
  input  logic          reset,
  memory_controller_if.slave bus
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int VRAM_AW = $clog2(VRAM_WORDS);

  region_e              region_p0, region_p1;
  arb_state_e           state, state_nxt;
  logic                 ram_we, cpu_vram_wr;
  logic                 vram_we, vid_grant;
  logic [VRAM_AW-1:0]   vram_addr, vid_addr_q;
  logic [WORD_W-1:0]    ram_q, vram_q;
  logic [WORD_W-1:0]    vram_latch, vid_hold;
  logic                 cpu_rd_p1;

  always_comb begin
    region_p0 = decode_region(bus.cpu_address);
`ifndef MEMORY_CONTROLLER_KEYBOARD_EN
    if (region_p0 == KBD) region_p0 = NONE;
`endif
  end

  assign ram_we      = bus.cpu_load && (region_p0 == RAM);
  assign cpu_vram_wr = bus.cpu_load && (region_p0 == VRAM);

  ram_bank #(.WORDS(RAM_WORDS), .ADDR_W(RAM_AW), .DATA_W(WORD_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (bus.cpu_address[RAM_AW-1:0]),
    .wdata (bus.cpu_wdata),
    .rdata (ram_q)
  );

  ram_bank #(.WORDS(VRAM_WORDS), .ADDR_W(VRAM_AW), .DATA_W(WORD_W)) u_vram (
    .clk   (clk),
    .we    (vram_we),
    .addr  (vram_addr),
    .wdata (bus.cpu_wdata),
    .rdata (vram_q)
  );

  // GUARD is CPU-owned and unstalled, so a CPU VRAM write there is committed too.
  always_comb begin
    state_nxt = state;
    vram_we   = 1'b0;
    vram_addr = bus.cpu_address[VRAM_AW-1:0];
    vid_grant = 1'b0;
    case (state)
      CPU_OWN: begin
        if (cpu_vram_wr) begin
          vram_we = 1'b1;
        end else if (bus.vid_req) begin
          vid_grant = 1'b1;
          state_nxt = VID_OWN;
        end
      end
      VID_OWN: begin
        vram_addr = vid_addr_q;
        state_nxt = GUARD;
      end
      GUARD: begin
        vram_we   = cpu_vram_wr;
        state_nxt = CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  // ---- stage p0 -> p1: arbiter state, region and CPU-read ownership ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= CPU_OWN;
      region_p1  <= NONE;
      cpu_rd_p1  <= 1'b0;
      vram_latch <= '0;
      vid_hold   <= '0;
    end else begin
      state     <= state_nxt;
      region_p1 <= region_p0;
      cpu_rd_p1 <= (state != VID_OWN);
      if (cpu_rd_p1)        vram_latch <= vram_q;
      if (state == GUARD)   vid_hold   <= vram_q;
    end
  end

  always_ff @(posedge clk) begin
    if (vid_grant) vid_addr_q <= bus.vid_address[VRAM_AW-1:0];
  end

`ifdef MEMORY_CONTROLLER_KEYBOARD_EN
  logic [WORD_W-1:0] kbd_q;

  always_ff @(posedge clk) begin
    if (reset) kbd_q <= '0;
    else       kbd_q <= bus.kbd_code;
  end
`else
  logic kbd_unused;
  assign kbd_unused = ^bus.kbd_code;
`endif

  // ---- stage p1: read return; a VRAM read that lost the port returns the latch ----
  always_comb begin
    bus.cpu_rdata = '0;
    case (region_p1)
      RAM:     bus.cpu_rdata = ram_q;
      VRAM:    bus.cpu_rdata = cpu_rd_p1 ? vram_q : vram_latch;
`ifdef MEMORY_CONTROLLER_KEYBOARD_EN
      KBD:     bus.cpu_rdata = kbd_q;
`endif
      default: bus.cpu_rdata = '0;
    endcase
  end

  assign bus.cpu_busy  = (state == VID_OWN);
  assign bus.vid_valid = (state == GUARD);
  assign bus.vid_rdata = (state == GUARD) ? vram_q : vid_hold;

endmodule

// File: tb/tb_memory_controller.sv
// Directed scoreboard bench for memory_controller (RAM, VRAM arbitration, KBD/NONE, reset).
module tb_memory_controller;
  import memory_map_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] cpu_q[$];
  string       cpu_tag_q[$];
  logic [15:0] vid_q[$];

  memory_controller_if bus ();

  memory_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [15:0] addr, input logic [15:0] wd);
    bus.cpu_load    = ld;
    bus.cpu_address = addr;
    bus.cpu_wdata   = wd;
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
    drive(1'b0, addr, 16'h0000);
    cpu_q.push_back(exp);
    cpu_tag_q.push_back(tag);
  endtask

  task automatic pop_cpu();
    string t;
    if (cpu_q.size() == 0) begin
      total++; bad++;
      $display("FAIL cpu_scoreboard observed=empty expected=entry");
    end else begin
      t = cpu_tag_q.pop_front();
      check(t, bus.cpu_rdata, cpu_q.pop_front());
    end
  endtask

  task automatic pop_vid(input string tag);
    if (vid_q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s observed=empty expected=entry", tag);
    end else begin
      check(tag, bus.vid_rdata, vid_q.pop_front());
    end
  endtask

  task automatic wait_vid(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (bus.vid_valid === 1'b1) found = 1'b1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL %s observed=no_vid_valid expected=vid_valid within 8 cycles", tag);
    end else begin
      pop_vid(tag);
    end
  endtask

  initial begin
    logic [15:0] kbd_exp;
    bit   [8:0]  exp_busy;
    bit   [8:0]  exp_valid;
    bit   [9:0]  busy_hist;

`ifdef MEMORY_CONTROLLER_KEYBOARD_EN
    kbd_exp = 16'h0041;
`else
    kbd_exp = 16'h0000;
`endif

    reset           = 1'b1;
    bus.vid_req     = 1'b0;
    bus.vid_address = '0;
    bus.kbd_code    = '0;
    drive(1'b0, 16'h0000, 16'h0000);
    tick();
    tick();
    check("rst_cpu_busy",  {15'd0, bus.cpu_busy},  16'd0);
    check("rst_vid_valid", {15'd0, bus.vid_valid}, 16'd0);
    check("rst_cpu_rdata", bus.cpu_rdata, 16'h0000);
    check("rst_vid_rdata", bus.vid_rdata, 16'h0000);
    reset = 1'b0;

    // RAM round trip
    drive(1'b1, 16'h0010, 16'h1234);
    tick();
    check("ram_wr_busy", {15'd0, bus.cpu_busy}, 16'd0);
    cpu_read(16'h0010, 16'h1234, "ram_rd_0010");
    tick();
    check("ram_rd_busy", {15'd0, bus.cpu_busy}, 16'd0);
    pop_cpu();

    // Preload RAM 0x2000 and VRAM 0x4005 / 0x4000
    drive(1'b1, 16'h2000, 16'h1111);  tick();
    drive(1'b1, 16'h4005, 16'hBEEF);  tick();
    drive(1'b1, 16'h4000, 16'hA5A5);  tick();
    cpu_read(16'h4005, 16'hBEEF, "vram_rd_4005");
    tick();
    pop_cpu();

    // Video priority: one busy cycle, then the strobe
    cpu_read(16'h0010, 16'h1234, "ram_rd_during_vid");
    bus.vid_req     = 1'b1;
    bus.vid_address = 13'h0005;
    vid_q.push_back(16'hBEEF);
    tick();
    pop_cpu();
    check("vidpri_busy",  {15'd0, bus.cpu_busy},  16'd1);
    check("vidpri_valid0", {15'd0, bus.vid_valid}, 16'd0);
    tick();
    check("vidpri_busy_guard", {15'd0, bus.cpu_busy},  16'd0);
    check("vidpri_valid",      {15'd0, bus.vid_valid}, 16'd1);
    pop_vid("vidpri_rdata");
    bus.vid_req = 1'b0;
    tick();
    check("vidpri_valid_drop", {15'd0, bus.vid_valid}, 16'd0);
    check("vidpri_hold",       bus.vid_rdata, 16'hBEEF);

    // Collision: CPU VRAM write wins the edge, video sees the new word
    drive(1'b1, 16'h4005, 16'h00FF);
    bus.vid_req     = 1'b1;
    bus.vid_address = 13'h0005;
    vid_q.push_back(16'h00FF);
    tick();
    check("coll_busy_stays_low", {15'd0, bus.cpu_busy}, 16'd0);
    drive(1'b0, 16'h4005, 16'h0000);
    wait_vid("coll_vid_rdata");
    bus.vid_req = 1'b0;
    tick();

    // Back-to-back video: states VID,GUARD,CPU repeat -> busy 1,0,0 and strobe 0,1,0
    exp_busy  = 9'b001_001_001;
    exp_valid = 9'b010_010_010;
    busy_hist = '0;
    drive(1'b0, 16'h4000, 16'h0000);
    bus.vid_req = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      busy_hist[k] = bus.cpu_busy;
      check($sformatf("b2b_busy_%0d", k), {15'd0, bus.cpu_busy}, {15'd0, exp_busy[k]});
      check($sformatf("b2b_valid_%0d", k), {15'd0, bus.vid_valid}, {15'd0, exp_valid[k]});
      if (exp_valid[k]) check($sformatf("b2b_vid_rdata_%0d", k), bus.vid_rdata, 16'h00FF);
      if (k >= 2 && !busy_hist[k-2])
        check($sformatf("b2b_cpu_rdata_%0d", k), bus.cpu_rdata, 16'hA5A5);
    end
    bus.vid_req = 1'b0;
    tick();

    // Keyboard and NONE regions
    bus.kbd_code = 16'h0041;
    cpu_read(16'h6000, kbd_exp, "kbd_rd");
    tick();
    pop_cpu();
    cpu_read(16'h7000, 16'h0000, "none_rd_7000");
    tick();
    pop_cpu();
    drive(1'b1, 16'h6000, 16'h5555);
    tick();
    cpu_read(16'h6000, kbd_exp, "kbd_rd_after_wr");
    tick();
    pop_cpu();
    cpu_read(16'h2000, 16'h1111, "ram_2000_untouched");
    tick();
    pop_cpu();
    cpu_read(16'h4000, 16'hA5A5, "vram_4000_untouched");
    tick();
    pop_cpu();

    // Reset while in VID_OWN
    drive(1'b1, 16'h0020, 16'hCAFE);
    tick();
    drive(1'b0, 16'h0020, 16'h0000);
    bus.vid_req     = 1'b1;
    bus.vid_address = 13'h0000;
    tick();
    check("rstvid_busy_before", {15'd0, bus.cpu_busy}, 16'd1);
    reset = 1'b1;
    tick();
    check("rstvid_busy",   {15'd0, bus.cpu_busy},  16'd0);
    check("rstvid_valid",  {15'd0, bus.vid_valid}, 16'd0);
    check("rstvid_state",  {14'd0, dut.state},     {14'd0, CPU_OWN});
    check("rstvid_vid_rdata", bus.vid_rdata, 16'h0000);
    reset       = 1'b0;
    bus.vid_req = 1'b0;
    cpu_read(16'h0020, 16'hCAFE, "rstvid_ram_0020");
    tick();
    pop_cpu();
    check("rstvid_valid_after1", {15'd0, bus.vid_valid}, 16'd0);
    cpu_read(16'h0010, 16'h1234, "rstvid_ram_0010");
    tick();
    pop_cpu();
    check("rstvid_valid_after2", {15'd0, bus.vid_valid}, 16'd0);
    check("rstvid_state_after",  {14'd0, dut.state}, {14'd0, CPU_OWN});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
